// File: rtl/lt_sequencer.sv
// Latency-tester measurement sequencer: frame-aligned box pattern, sensor timing.
// Define LT_AUTOCYCLE_EN to let auto_cycle step through all three positions.
module lt_sequencer #(
  parameter int SETTLE_FRAMES  = 4,
  parameter int TIMEOUT_FRAMES = 30,
  parameter int CNT_W          = 24
) (
  input  logic             clk27,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode_sel,
  input  logic             auto_cycle,
  input  logic             VSYNC_in,
  input  logic             sensor_in,
  output logic             lt_active,
  output logic [1:0]       lt_mode,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] result,
  output logic [1:0]       result_pos
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ARM,
    S_MEAS,
    S_REPORT
  } state_t;

  localparam logic [8:0] SET_N   = 9'(SETTLE_FRAMES);
  localparam logic [8:0] TO_N    = 9'(TIMEOUT_FRAMES);
  localparam logic [8:0] SETTO_N = 9'(SETTLE_FRAMES + TIMEOUT_FRAMES);

  state_t           r_state;
  logic             r_s1, r_s2, r_s3, r_rise, r_vs;
  logic [8:0]       r_frm;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_pos;
  logic             r_auto;
  logic             r_active, r_busy, r_done, r_timeout;
  logic [1:0]       r_mode, r_result_pos;
  logic [CNT_W-1:0] r_result;

  logic       w_vs_fall;
  logic       w_auto;
  logic [1:0] w_pos0;
  logic [8:0] w_frm_inc;

`ifdef LT_AUTOCYCLE_EN
  assign w_auto = auto_cycle;
`else
  logic w_unused_auto;
  assign w_unused_auto = auto_cycle;
  assign w_auto        = 1'b0;
`endif

  assign w_vs_fall = r_vs & ~VSYNC_in;
  assign w_pos0    = w_auto ? 2'd1 : mode_sel;
  assign w_frm_inc = r_frm + 9'd1;

  // 2-FF synchronizer, then a registered rising-edge detect
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
      r_vs   <= 1'b0;
    end else begin
      r_s1   <= sensor_in;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
      r_vs   <= VSYNC_in;
    end
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_frm        <= '0;
      r_cnt        <= '0;
      r_pos        <= 2'd0;
      r_auto       <= 1'b0;
      r_active     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_mode       <= 2'd0;
      r_result_pos <= 2'd0;
      r_result     <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort && r_state != S_IDLE) begin
        r_state  <= S_IDLE;
        r_busy   <= 1'b0;
        r_active <= 1'b0;
        r_mode   <= 2'd0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start && w_pos0 != 2'd0) begin
              r_auto   <= w_auto;
              r_pos    <= w_pos0;
              r_frm    <= '0;
              r_busy   <= 1'b1;
              r_active <= 1'b1;
              r_mode   <= 2'd0;
              r_state  <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (r_frm >= SET_N && !r_s2) begin
              r_state <= S_ARM;
            end else if (w_vs_fall) begin
              r_frm <= w_frm_inc;
              // lit sensor: the extra frames eat into the timeout budget
              if (w_frm_inc == SETTO_N) begin
                r_result     <= '1;
                r_timeout    <= 1'b1;
                r_result_pos <= r_pos;
                r_done       <= 1'b1;
                r_mode       <= 2'd0;
                r_state      <= S_REPORT;
              end
            end
          end
          S_ARM: begin
            if (w_vs_fall) begin
              r_mode  <= r_pos;
              r_cnt   <= '0;
              r_frm   <= '0;
              r_state <= S_MEAS;
            end
          end
          S_MEAS: begin
            if (!(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
            if (r_rise) begin
              r_result     <= r_cnt;
              r_timeout    <= 1'b0;
              r_result_pos <= r_pos;
              r_done       <= 1'b1;
              r_mode       <= 2'd0;
              r_state      <= S_REPORT;
            end else if (w_vs_fall) begin
              r_frm <= w_frm_inc;
              if (w_frm_inc == TO_N) begin
                r_result     <= '1;
                r_timeout    <= 1'b1;
                r_result_pos <= r_pos;
                r_done       <= 1'b1;
                r_mode       <= 2'd0;
                r_state      <= S_REPORT;
              end
            end
          end
          S_REPORT: begin
            if (r_auto && r_pos != 2'd3) begin
              r_pos   <= r_pos + 2'd1;
              r_frm   <= '0;
              r_state <= S_SETTLE;
            end else begin
              r_busy   <= 1'b0;
              r_active <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign lt_active  = r_active;
  assign lt_mode    = r_mode;
  assign busy       = r_busy;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign result     = r_result;
  assign result_pos = r_result_pos;

endmodule

// File: tb/tb_lt_sequencer.sv
// Randomized bench for lt_sequencer with a frame-level latency model.
// Covers single runs, timeouts, abort, lit sensor, auto-cycle and reset.
module tb_lt_sequencer;

  localparam int FRAME = 1000;
  localparam int TO_F  = 2;

  logic        clk27, reset_n, start, abort, auto_cycle;
  logic        VSYNC_in, sensor_in;
  logic [1:0]  mode_sel;
  logic        lt_active, busy, done, timeout;
  logic [1:0]  lt_mode, result_pos;
  logic [23:0] result;

  int n_chk, n_err, vcnt, nfall;
  bit busy_gap;
  logic [23:0] last_res;
  logic [1:0]  last_pos;
  logic        last_to;

  lt_sequencer #(
    .SETTLE_FRAMES (1),
    .TIMEOUT_FRAMES(TO_F),
    .CNT_W         (24)
  ) dut (
    .clk27     (clk27),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .mode_sel  (mode_sel),
    .auto_cycle(auto_cycle),
    .VSYNC_in  (VSYNC_in),
    .sensor_in (sensor_in),
    .lt_active (lt_active),
    .lt_mode   (lt_mode),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .result    (result),
    .result_pos(result_pos)
  );

  initial begin
    clk27 = 1'b0;
    forever #5 clk27 = ~clk27;
  end

  initial begin
    vcnt     = 0;
    nfall    = 0;
    VSYNC_in = 1'b1;
    forever begin
      @(negedge clk27);
      vcnt     = (vcnt + 1) % FRAME;
      VSYNC_in = (vcnt >= 8);
      if (vcnt == 0) nfall++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [1:0] pos, input logic a);
    mode_sel   = pos;
    auto_cycle = a;
    start      = 1'b1;
    @(posedge clk27); #1;
    start      = 1'b0;
    auto_cycle = 1'b0;
  endtask

  task automatic wait_mode(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk27); #1;
      if (!busy) busy_gap = 1;
      if (lt_mode != 2'd0) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Sensor rises d cycles after the box appears; 3 cycles of sync delay
  // are added, and the 2nd frame edge after arming wins only if earlier.
  task automatic meas_body(input logic [1:0] pos, input int d,
                           input logic exp_busy);
    bit ok;
    int t, lat;
    logic [23:0] er;
    logic et;
    wait_mode(ok);
    check("arm_seen", ok, 1);
    if (!ok) return;
    check("meas_mode", lt_mode, pos);
    if (d + 3 <= TO_F * FRAME - 1) begin
      er = 24'(d + 3); et = 1'b0; lat = d + 4;
    end else begin
      er = 24'hFFFFFF; et = 1'b1; lat = TO_F * FRAME;
    end
    if (d == 0) sensor_in = 1'b1;
    ok = 0;
    for (t = 1; t <= 2500; t++) begin
      @(posedge clk27); #1;
      if (!busy) busy_gap = 1;
      if (done) begin
        ok = 1;
        break;
      end
      if (t == d) sensor_in = 1'b1;
    end
    check("done_seen", ok, 1);
    check("latency", t, lat);
    check("result", result, er);
    check("timeout", timeout, et);
    check("result_pos", result_pos, pos);
    check("mode_report", lt_mode, 0);
    last_res  = er;
    last_pos  = pos;
    last_to   = et;
    sensor_in = 1'b0;
    @(posedge clk27); #1;
    check("done_pulse", done, 0);
    check("busy_after", busy, exp_busy);
    check("active_after", lt_active, exp_busy);
  endtask

  task automatic measure(input logic [1:0] pos, input int d);
    pulse_start(pos, 1'b0);
    check("start_busy", busy, 1);
    check("start_active", lt_active, 1);
    meas_body(pos, d, 1'b0);
  endtask

  initial begin
    bit ok;
    int nd, n0;
    bit lit_mode;
    n_chk      = 0;
    n_err      = 0;
    busy_gap   = 0;
    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    auto_cycle = 1'b0;
    mode_sel   = 2'd0;
    sensor_in  = 1'b0;
    repeat (3) @(posedge clk27);
    #1;
    check("rst_busy", busy, 0);
    check("rst_active", lt_active, 0);
    check("rst_mode", lt_mode, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_result", result, 0);
    check("rst_pos", result_pos, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk27);
    #1;

    pulse_start(2'd0, 1'b0);
    check("start0_busy", busy, 0);
    check("start0_active", lt_active, 0);

    measure(2'd2, 500);
    measure(2'd1, 100000);
    measure(2'd3, 1996);
    measure(2'd2, 1997);
    for (int i = 0; i < 6; i++)
      measure(2'($urandom_range(1, 3)), int'($urandom_range(0, 2100)));

    pulse_start(2'd3, 1'b0);
    wait_mode(ok);
    check("abort_arm", ok, 1);
    repeat (100) @(posedge clk27);
    #1;
    abort = 1'b1;
    @(posedge clk27); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_active", lt_active, 0);
    check("abort_mode", lt_mode, 0);
    nd = 0;
    repeat (2100) begin
      @(posedge clk27); #1;
      if (done) nd++;
    end
    check("abort_nodone", nd, 0);
    check("abort_result", result, last_res);
    check("abort_pos", result_pos, last_pos);
    check("abort_to", timeout, last_to);

    sensor_in = 1'b1;
    pulse_start(2'd1, 1'b0);
    n0 = nfall;
    lit_mode = 0;
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk27); #1;
      if (lt_mode != 2'd0) lit_mode = 1;
      if (done) begin
        ok = 1;
        break;
      end
    end
    check("lit_done", ok, 1);
    check("lit_frames", nfall - n0, 1 + TO_F);
    check("lit_noarm", lit_mode, 0);
    check("lit_result", result, 24'hFFFFFF);
    check("lit_timeout", timeout, 1);
    check("lit_pos", result_pos, 1);
    last_res  = 24'hFFFFFF;
    last_pos  = 2'd1;
    last_to   = 1'b1;
    sensor_in = 1'b0;
    @(posedge clk27); #1;
    check("lit_idle", busy, 0);

    pulse_start(2'd2, 1'b0);
    repeat (5) @(posedge clk27);
    #1;
    pulse_start(2'd1, 1'b0);
    check("busy_start", busy, 1);
    wait_mode(ok);
    check("busy_start_mode", lt_mode, 2);
    abort = 1'b1;
    @(posedge clk27); #1;
    abort = 1'b0;
    check("busy_abort", busy, 0);

`ifdef LT_AUTOCYCLE_EN
    busy_gap = 0;
    pulse_start(2'd0, 1'b1);
    check("auto_busy", busy, 1);
    for (int k = 1; k <= 3; k++)
      meas_body(2'(k), 10, (k < 3));
    check("auto_gap", busy_gap, 0);
`else
    pulse_start(2'd3, 1'b1);
    check("noauto_busy", busy, 1);
    meas_body(2'd3, 10, 1'b0);
`endif

    pulse_start(2'd1, 1'b0);
    wait_mode(ok);
    repeat (50) @(posedge clk27);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_active", lt_active, 0);
    check("arst_mode", lt_mode, 0);
    check("arst_result", result, 0);
    @(posedge clk27); #1;
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
